// File: rtl/uart_frame_assembler.sv
// Purpose: assemble one sync-framed, checksummed grayscale frame from UART byte strobes into frame RAM.
// Latency: each pixel byte is written to RAM one cycle after its strobe; status flags update one cycle after the deciding byte.
// Backpressure: drops fpga_can_receive while a verified frame is held; bytes arriving then are dropped and flagged as overflow.
module uart_frame_assembler #(
  parameter int          IMG_W  = 320,
  parameter int          IMG_H  = 240,
  parameter int          ADDR_W = 17,
  parameter logic [7:0]  SYNC0  = 8'hA5,
  parameter logic [7:0]  SYNC1  = 8'h5A
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              uart_data_rdy,
  input  logic [7:0]        uart_data,
  input  logic              frame_release,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              fpga_can_receive,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              overflow
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    PIXELS = 3'd2,
    CHECK  = 3'd3,
    FULL   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rts_q, rts_d;
  logic              fvalid_q, fvalid_d;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;

  // Next-state and registered-output decode; everything holds unless a strobe or release acts on it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rts_d    = rts_q;
    fvalid_d = fvalid_q;
    ferr_d   = ferr_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (uart_data_rdy && uart_data == SYNC0) state_d = SYNC;
      end
      SYNC: begin
        if (uart_data_rdy) begin
          if (uart_data == SYNC1) begin
            state_d = PIXELS;
            cnt_d   = '0;
            csum_d  = '0;
            ferr_d  = 1'b0;
          end else if (uart_data != SYNC0) begin
            state_d = IDLE;
          end
        end
      end
      PIXELS: begin
        if (uart_data_rdy) begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = uart_data;
          csum_d  = csum_q + uart_data;
          // Hold the counter on the last pixel so it never wraps into the next frame.
          if (cnt_q == LAST_PIX) state_d = CHECK;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (uart_data_rdy) begin
          if (uart_data == csum_q) begin
            state_d  = FULL;
            fvalid_d = 1'b1;
            rts_d    = 1'b0;
          end else begin
            state_d = IDLE;
            ferr_d  = 1'b1;
          end
        end
      end
      FULL: begin
        // Release takes priority over a coincident in-flight byte, which is then silently dropped.
        if (frame_release) begin
          state_d  = IDLE;
          fvalid_d = 1'b0;
          rts_d    = 1'b1;
          ovf_d    = 1'b0;
        end else if (uart_data_rdy) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      csum_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rts_q    <= 1'b1;
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rts_q    <= rts_d;
      fvalid_q <= fvalid_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign mem_we           = we_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign fpga_can_receive = rts_q;
  assign frame_valid      = fvalid_q;
  assign frame_err        = ferr_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Bench for uart_frame_assembler with a 4x2 frame: byte streams are built from the framing rules,
// expected RAM writes and checksums come from plain arithmetic over the pixel list.
module tb_uart_frame_assembler;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          uart_data_rdy;
  logic [7:0]    uart_data;
  logic          frame_release;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          fpga_can_receive;
  logic          frame_valid;
  logic          frame_err;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] tx_q[$];
  int         stb_c[$];
  int         wr_a[$];
  int         wr_d[$];
  int         wr_c[$];
  logic [7:0] exp_pix[N];

  uart_frame_assembler #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
    .clock(clock), .reset_n(reset_n), .uart_data_rdy(uart_data_rdy), .uart_data(uart_data),
    .frame_release(frame_release), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fpga_can_receive(fpga_can_receive), .frame_valid(frame_valid), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Write monitor: records every RAM write with the cycle it became visible.
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      wr_a.push_back(int'(mem_addr));
      wr_d.push_back(int'(mem_wdata));
      wr_c.push_back(cyc);
    end
  end

  function automatic logic [7:0] csum_of();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(exp_pix[i]);
    return 8'(s % 256);
  endfunction

  task automatic clear_writes();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
  endtask

  // Build A5 5A + pixels + trailer into tx_q.
  task automatic build_frame(input logic [7:0] trailer);
    tx_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h5A);
    for (int i = 0; i < N; i++) tx_q.push_back(exp_pix[i]);
    tx_q.push_back(trailer);
  endtask

  task automatic random_pixels();
    for (int i = 0; i < N; i++) exp_pix[i] = 8'($urandom_range(255, 0));
  endtask

  // Drive tx_q as one-cycle strobes with up to max_gap idle cycles between them.
  task automatic send_all(input int max_gap);
    stb_c.delete();
    foreach (tx_q[i]) begin
      @(negedge clock);
      uart_data_rdy = 1'b1;
      uart_data = tx_q[i];
      stb_c.push_back(cyc);
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(max_gap, 0);
        repeat (g) begin
          @(negedge clock);
          uart_data_rdy = 1'b0;
        end
      end
    end
    @(negedge clock);
    uart_data_rdy = 1'b0;
  endtask

  task automatic pulse_release();
    @(negedge clock);
    frame_release = 1'b1;
    @(negedge clock);
    frame_release = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_mem got we=%b addr=%0d data=%h want 0/0/00", mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({fpga_can_receive, frame_valid, frame_err, overflow} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags got rts/fv/err/ovf=%b want 1000",
                         {fpga_can_receive, frame_valid, frame_err, overflow});
    end
  endtask

  task automatic test_clean_frame();
    for (int i = 0; i < N; i++) exp_pix[i] = 8'(i + 1);
    build_frame(8'h24);
    clear_writes();
    send_all(0);
    checks++;
    if (wr_a.size() !== N) begin errors++; $display("FAIL clean_wr_count got %0d want %0d", wr_a.size(), N); end
    for (int i = 0; i < wr_a.size() && i < N; i++) begin
      checks++;
      if (wr_a[i] !== i || wr_d[i] !== int'(exp_pix[i]) || wr_c[i] - stb_c[i+2] !== 1) begin
        errors++; $display("FAIL clean_wr%0d got a=%0d d=%h lat=%0d want a=%0d d=%h lat=1",
                           i, wr_a[i], wr_d[i], wr_c[i] - stb_c[i+2], i, exp_pix[i]);
      end
    end
    checks++;
    if ({frame_valid, fpga_can_receive, frame_err} !== 3'b100) begin
      errors++; $display("FAIL clean_flags got fv/rts/err=%b want 100", {frame_valid, fpga_can_receive, frame_err});
    end
    pulse_release();
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      bit good;
      logic [7:0] ck;
      good = ($urandom_range(1, 0) == 1);
      random_pixels();
      ck = csum_of();
      build_frame(good ? ck : ck + 8'($urandom_range(255, 1)));
      clear_writes();
      send_all(2);
      checks++;
      if (wr_a.size() !== N) begin errors++; $display("FAIL rnd%0d_wr_count got %0d want %0d", f, wr_a.size(), N); end
      for (int i = 0; i < wr_a.size() && i < N; i++) begin
        checks++;
        if (wr_a[i] !== i || wr_d[i] !== int'(exp_pix[i]) || wr_c[i] - stb_c[i+2] !== 1) begin
          errors++; $display("FAIL rnd%0d_wr%0d got a=%0d d=%h lat=%0d want a=%0d d=%h lat=1",
                             f, i, wr_a[i], wr_d[i], wr_c[i] - stb_c[i+2], i, exp_pix[i]);
        end
      end
      checks++;
      if ({frame_valid, fpga_can_receive, frame_err} !== (good ? 3'b100 : 3'b011)) begin
        errors++; $display("FAIL rnd%0d_flags got fv/rts/err=%b want %b", f,
                           {frame_valid, fpga_can_receive, frame_err}, good ? 3'b100 : 3'b011);
      end
      if (good) pulse_release();
    end
  endtask

  task automatic test_bad_then_clean();
    random_pixels();
    build_frame(csum_of() + 8'd1);
    clear_writes();
    send_all(1);
    checks++;
    if (wr_a.size() !== N || {frame_valid, frame_err, fpga_can_receive} !== 3'b011) begin
      errors++; $display("FAIL bad_ck got writes=%0d fv/err/rts=%b want %0d 011",
                         wr_a.size(), {frame_valid, frame_err, fpga_can_receive}, N);
    end
    random_pixels();
    build_frame(csum_of());
    send_all(1);
    checks++;
    if ({frame_valid, frame_err, fpga_can_receive} !== 3'b100) begin
      errors++; $display("FAIL bad_then_clean got fv/err/rts=%b want 100", {frame_valid, frame_err, fpga_can_receive});
    end
    pulse_release();
  endtask

  task automatic test_sync_hunt();
    for (int i = 0; i < N; i++) exp_pix[i] = 8'(i + 1);
    tx_q.delete();
    tx_q.push_back(8'h00); tx_q.push_back(8'hA5); tx_q.push_back(8'hA5); tx_q.push_back(8'h5A);
    for (int i = 0; i < N; i++) tx_q.push_back(exp_pix[i]);
    tx_q.push_back(csum_of());
    clear_writes();
    send_all(1);
    checks++;
    if (wr_a.size() !== N || (wr_a.size() > 0 && wr_a[0] !== 0) || frame_valid !== 1'b1) begin
      errors++; $display("FAIL hunt_accept got writes=%0d fv=%b want %0d 1", wr_a.size(), frame_valid, N);
    end
    pulse_release();
    tx_q.delete();
    tx_q.push_back(8'h00); tx_q.push_back(8'hA5); tx_q.push_back(8'h33); tx_q.push_back(8'h5A);
    for (int i = 0; i < N; i++) tx_q.push_back(exp_pix[i]);
    tx_q.push_back(csum_of());
    clear_writes();
    send_all(1);
    checks++;
    if (wr_a.size() !== 0 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL hunt_reject got writes=%0d fv=%b want 0 0", wr_a.size(), frame_valid);
    end
  endtask

  task automatic test_overflow_release();
    random_pixels();
    build_frame(csum_of());
    send_all(0);
    tx_q.delete();
    tx_q.push_back(8'($urandom_range(255, 0)));
    tx_q.push_back(8'($urandom_range(255, 0)));
    clear_writes();
    send_all(1);
    checks++;
    if (wr_a.size() !== 0 || {overflow, frame_valid, fpga_can_receive} !== 3'b110) begin
      errors++; $display("FAIL ovf_set got writes=%0d ovf/fv/rts=%b want 0 110",
                         wr_a.size(), {overflow, frame_valid, fpga_can_receive});
    end
    pulse_release();
    checks++;
    if ({overflow, frame_valid, fpga_can_receive} !== 3'b001) begin
      errors++; $display("FAIL ovf_release got ovf/fv/rts=%b want 001", {overflow, frame_valid, fpga_can_receive});
    end
  endtask

  task automatic test_simultaneous();
    random_pixels();
    build_frame(csum_of());
    send_all(0);
    @(negedge clock);
    frame_release = 1'b1;
    uart_data_rdy = 1'b1;
    uart_data = 8'hA5;
    @(negedge clock);
    frame_release = 1'b0;
    uart_data_rdy = 1'b0;
    checks++;
    if ({overflow, frame_valid, fpga_can_receive} !== 3'b001) begin
      errors++; $display("FAIL simul_flags got ovf/fv/rts=%b want 001", {overflow, frame_valid, fpga_can_receive});
    end
    // The dropped A5 must not have started sync, so this tail is ignored.
    tx_q.delete();
    tx_q.push_back(8'h5A);
    for (int i = 0; i < N; i++) tx_q.push_back(8'(i + 1));
    tx_q.push_back(8'h24);
    clear_writes();
    send_all(0);
    checks++;
    if (wr_a.size() !== 0 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL simul_idle got writes=%0d fv=%b want 0 0", wr_a.size(), frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) exp_pix[i] = 8'hFF;
    build_frame(csum_of());
    clear_writes();
    send_all(0);
    checks++;
    if (tx_q[N+2] !== 8'hF8 || wr_a.size() !== N || frame_valid !== 1'b1) begin
      errors++; $display("FAIL b2b got trailer=%h writes=%0d fv=%b want F8 %0d 1",
                         tx_q[N+2], wr_a.size(), frame_valid, N);
    end
    for (int i = 0; i < wr_a.size() && i < N; i++) begin
      checks++;
      if (wr_a[i] !== i || wr_d[i] !== 255 || wr_c[i] - stb_c[i+2] !== 1) begin
        errors++; $display("FAIL b2b_wr%0d got a=%0d d=%h lat=%0d want a=%0d d=ff lat=1",
                           i, wr_a[i], wr_d[i], wr_c[i] - stb_c[i+2], i);
      end
    end
    pulse_release();
  endtask

  task automatic test_reset_mid();
    random_pixels();
    tx_q.delete();
    tx_q.push_back(8'hA5); tx_q.push_back(8'h5A);
    for (int i = 0; i < 3; i++) tx_q.push_back(exp_pix[i]);
    send_all(0);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== '0 ||
        {fpga_can_receive, frame_valid, frame_err, overflow} !== 4'b1000) begin
      errors++; $display("FAIL rst_mid got we=%b addr=%0d data=%h rts/fv/err/ovf=%b want 0 0 00 1000",
                         mem_we, mem_addr, mem_wdata, {fpga_can_receive, frame_valid, frame_err, overflow});
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    random_pixels();
    build_frame(csum_of());
    clear_writes();
    send_all(1);
    checks++;
    if (wr_a.size() !== N || frame_valid !== 1'b1) begin
      errors++; $display("FAIL rst_fresh got writes=%0d fv=%b want %0d 1", wr_a.size(), frame_valid, N);
    end
    for (int i = 0; i < wr_a.size() && i < N; i++) begin
      checks++;
      if (wr_a[i] !== i || wr_d[i] !== int'(exp_pix[i])) begin
        errors++; $display("FAIL rst_fresh_wr%0d got a=%0d d=%h want a=%0d d=%h", i, wr_a[i], wr_d[i], i, exp_pix[i]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    uart_data_rdy = 1'b0;
    uart_data = 8'h00;
    frame_release = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    @(negedge clock);
    test_reset();
    test_clean_frame();
    test_random_frames();
    test_bad_then_clean();
    test_sync_hunt();
    test_overflow_release();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
